// File: rtl/nfu_pipeline_hs.sv
// nfu_pipeline_hs: 4-stage valid/ready NFU datapath (input reg, multiply, adder tree + accumulate, activation/output reg).
// Build option NFU_RELU_EN: when defined, final (o_last) results pass through ReLU; otherwise they pass unchanged.
module nfu_pipeline_hs #(
    parameter int BIT_WIDTH = 16,
    parameter int TN        = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [BIT_WIDTH*TN-1:0]       i_inputs,
    input  logic [BIT_WIDTH*TN*TN-1:0]    i_synapses,
    input  logic                          i_first,
    input  logic [BIT_WIDTH*TN-1:0]       i_psum,
    input  logic                          i_last,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [BIT_WIDTH*TN-1:0]       o_to_nbout,
    output logic                          o_last
);
    localparam int W  = BIT_WIDTH;
    localparam int PW = 2 * BIT_WIDTH;
    localparam int TW = BIT_WIDTH + $clog2(TN) + 1;
    localparam int AW = TW + 1;

    // Clamp a shifted product back to the word range.
    function automatic logic [W-1:0] sat_prod(input logic [PW-1:0] v);
        logic [W-1:0] r;
        if ((v[PW-1:W-1] == {(PW-W+1){1'b0}}) || (v[PW-1:W-1] == {(PW-W+1){1'b1}})) begin
            r = v[W-1:0];
        end else if (v[PW-1]) begin
            r = {1'b1, {(W-1){1'b0}}};
        end else begin
            r = {1'b0, {(W-1){1'b1}}};
        end
        return r;
    endfunction

    // Clamp a tree + accumulator sum back to the word range.
    function automatic logic [W-1:0] sat_acc(input logic [AW-1:0] v);
        logic [W-1:0] r;
        if ((v[AW-1:W-1] == {(AW-W+1){1'b0}}) || (v[AW-1:W-1] == {(AW-W+1){1'b1}})) begin
            r = v[W-1:0];
        end else if (v[AW-1]) begin
            r = {1'b1, {(W-1){1'b0}}};
        end else begin
            r = {1'b0, {(W-1){1'b1}}};
        end
        return r;
    endfunction

    // Activation applied only to final results.
    function automatic logic [W-1:0] act(input logic [W-1:0] v);
`ifdef NFU_RELU_EN
        return v[W-1] ? {W{1'b0}} : v;
`else
        return v;
`endif
    endfunction

    logic                   w_adv;
    logic                   r_s0_valid, r_s0_first, r_s0_last;
    logic [W*TN-1:0]        r_s0_x, r_s0_psum;
    logic [W*TN*TN-1:0]     r_s0_w;
    logic                   r_s1_valid, r_s1_first, r_s1_last;
    logic [W*TN*TN-1:0]     r_s1_p;
    logic [W*TN-1:0]        r_s1_psum;
    logic                   r_s2_valid, r_s2_first, r_s2_last;
    logic [TW*TN-1:0]       r_s2_tree;
    logic [W*TN-1:0]        r_s2_psum;
    logic [W*TN-1:0]        r_acc;
    logic                   r_o_valid, r_o_last;
    logic [W*TN-1:0]        r_out;

    logic [PW-1:0]          w_xe, w_we;
    logic signed [PW-1:0]   w_prod, w_sh;
    logic [W*TN*TN-1:0]     w_p;
    logic [TW-1:0]          w_sum;
    logic [TW*TN-1:0]       w_tree;
    logic [AW-1:0]          w_base, w_total;
    logic [W-1:0]           w_sat;
    logic [W*TN-1:0]        w_acc_next, w_out_next;

    assign w_adv      = !r_o_valid || i_ready;
    assign o_ready    = w_adv && !rst;
    assign o_valid    = r_o_valid;
    assign o_last     = r_o_last;
    assign o_to_nbout = r_out;

    // S1 combinational: fixed-point products, rescaled and saturated.
    always_comb begin
        w_p    = {(W*TN*TN){1'b0}};
        w_xe   = {PW{1'b0}};
        w_we   = {PW{1'b0}};
        w_prod = {PW{1'b0}};
        w_sh   = {PW{1'b0}};
        for (int n = 0; n < TN; n++) begin
            for (int i = 0; i < TN; i++) begin
                w_xe   = {{(PW-W){r_s0_x[i*W+W-1]}}, r_s0_x[i*W +: W]};
                w_we   = {{(PW-W){r_s0_w[(n*TN+i)*W+W-1]}}, r_s0_w[(n*TN+i)*W +: W]};
                w_prod = $signed(w_xe) * $signed(w_we);
                w_sh   = w_prod >>> FRAC_BITS;
                w_p[(n*TN+i)*W +: W] = sat_prod(w_sh);
            end
        end
    end

    // S2 entry combinational: per-lane adder tree, wide enough never to overflow.
    always_comb begin
        w_tree = {(TW*TN){1'b0}};
        w_sum  = {TW{1'b0}};
        for (int n = 0; n < TN; n++) begin
            w_sum = {TW{1'b0}};
            for (int i = 0; i < TN; i++) begin
                w_sum = w_sum + {{(TW-W){r_s1_p[(n*TN+i)*W+W-1]}}, r_s1_p[(n*TN+i)*W +: W]};
            end
            w_tree[n*TW +: TW] = w_sum;
        end
    end

    // S2 combinational: seed from psum on first beats, else fold onto the running accumulator.
    always_comb begin
        w_acc_next = {(W*TN){1'b0}};
        w_out_next = {(W*TN){1'b0}};
        w_base     = {AW{1'b0}};
        w_total    = {AW{1'b0}};
        w_sat      = {W{1'b0}};
        for (int n = 0; n < TN; n++) begin
            if (r_s2_first) begin
                w_base = {{(AW-W){r_s2_psum[n*W+W-1]}}, r_s2_psum[n*W +: W]};
            end else begin
                w_base = {{(AW-W){r_acc[n*W+W-1]}}, r_acc[n*W +: W]};
            end
            w_total = {r_s2_tree[n*TW+TW-1], r_s2_tree[n*TW +: TW]} + w_base;
            w_sat   = sat_acc(w_total);
            w_acc_next[n*W +: W] = w_sat;
            w_out_next[n*W +: W] = r_s2_last ? act(w_sat) : w_sat;
        end
    end

    // S0: capture an accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0_valid <= 1'b0;
            r_s0_first <= 1'b0;
            r_s0_last  <= 1'b0;
            r_s0_x     <= {(W*TN){1'b0}};
            r_s0_psum  <= {(W*TN){1'b0}};
            r_s0_w     <= {(W*TN*TN){1'b0}};
        end else if (w_adv) begin
            r_s0_valid <= i_valid;
            if (i_valid) begin
                r_s0_first <= i_first;
                r_s0_last  <= i_last;
                r_s0_x     <= i_inputs;
                r_s0_psum  <= i_psum;
                r_s0_w     <= i_synapses;
            end
        end
    end

    // S1: register products and the beat's side-band.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_p     <= {(W*TN*TN){1'b0}};
            r_s1_psum  <= {(W*TN){1'b0}};
        end else if (w_adv) begin
            r_s1_valid <= r_s0_valid;
            r_s1_first <= r_s0_first;
            r_s1_last  <= r_s0_last;
            r_s1_p     <= w_p;
            r_s1_psum  <= r_s0_psum;
        end
    end

    // S2: register tree sums; the accumulator feeds back here so back-to-back beats need no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_first <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_tree  <= {(TW*TN){1'b0}};
            r_s2_psum  <= {(W*TN){1'b0}};
            r_acc      <= {(W*TN){1'b0}};
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_first <= r_s1_first;
            r_s2_last  <= r_s1_last;
            r_s2_tree  <= w_tree;
            r_s2_psum  <= r_s1_psum;
            if (r_s2_valid) begin
                r_acc <= w_acc_next;
            end
        end
    end

    // S3: output register, frozen while the writer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_o_valid <= 1'b0;
            r_o_last  <= 1'b0;
            r_out     <= {(W*TN){1'b0}};
        end else if (w_adv) begin
            r_o_valid <= r_s2_valid;
            r_o_last  <= r_s2_valid && r_s2_last;
            if (r_s2_valid) begin
                r_out <= w_out_next;
            end
        end
    end
endmodule
